// File: rtl/mode_pulse_pkg.sv
// Shared definitions for the mode pulse decoder: mode codes,
// 7-segment digits (active low, {g,f,e,d,c,b,a}) and divider default.
package mode_pulse_pkg;

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_SLOW = 2'd1;
    localparam logic [1:0] MODE_MED  = 2'd2;
    localparam logic [1:0] MODE_FAST = 2'd3;

    localparam logic [6:0] SEG_OFF  = 7'b1000000;
    localparam logic [6:0] SEG_SLOW = 7'b1111001;
    localparam logic [6:0] SEG_MED  = 7'b0100100;
    localparam logic [6:0] SEG_FAST = 7'b0110000;

    localparam int DIV_BASE_DEFAULT = 4;

    // Burst pattern in the fast mode: periods 0..2 pulse, 3..5 silent.
    localparam int BURST_PERIODS = 6;
    localparam int BURST_ON      = 3;

    function automatic logic [6:0] mode_seg(input logic [1:0] m);
        case (m)
            MODE_OFF:  return SEG_OFF;
            MODE_SLOW: return SEG_SLOW;
            MODE_MED:  return SEG_MED;
            default:   return SEG_FAST;
        endcase
    endfunction

endpackage

// File: rtl/code_sync.sv
// Two-flop synchronizer for the asynchronous mode code, followed by
// a one-cycle stability register; stable_o flags sync == prev.
module code_sync
    import mode_pulse_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] code_i,
    output logic [1:0] code_o,
    output logic       stable_o
);

    logic [1:0] s1_q, s1_d;
    logic [1:0] s2_q, s2_d;
    logic [1:0] prev_q, prev_d;

    // Shift the raw code through the synchronizer and history stage.
    always_comb begin
        s1_d   = code_i;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // Synchronizer and history flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= MODE_OFF;
            s2_q   <= MODE_OFF;
            prev_q <= MODE_OFF;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign code_o   = s2_q;
    assign stable_o = (s2_q == prev_q);

endmodule

// File: rtl/mode_pulse_decoder.sv
// Mode decoder: filtered 2-bit code selects a 50% pulse train and a
// 7-segment digit. Define PULSE_BURST_EN for 3-on/3-off fast bursts.
module mode_pulse_decoder
    import mode_pulse_pkg::*;
#(
    parameter int DIV_BASE = DIV_BASE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_a,
    input  logic       code_b,
    output logic [1:0] mode,
    output logic       mode_chg,
    output logic       pulse_out,
    output logic [6:0] seg_n
);

    localparam int PW = DIV_BASE + 2;

    logic [1:0]    sync_code;
    logic          sync_stable;
    logic          upd;

    logic [1:0]    mode_q, mode_d;
    logic          chg_q, chg_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          pulse_q, pulse_d;
    logic [6:0]    seg_q, seg_d;
    logic          pulse_raw;
    logic          burst_mute;

    code_sync u_code_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .code_i   ({code_b, code_a}),
        .code_o   (sync_code),
        .stable_o (sync_stable)
    );

    // A code seen twice in a row that differs from mode is accepted.
    assign upd = sync_stable && (sync_code != mode_q);

    // Next mode, strobe, digit and phase; phase restarts on every update.
    always_comb begin
        mode_d  = upd ? sync_code : mode_q;
        chg_d   = upd;
        seg_d   = mode_seg(mode_d);
        phase_d = phase_q + PW'(1);
        if (upd || (mode_d == MODE_OFF)) begin
            phase_d = '0;
        end
    end

    // Half-period bit of the phase counter for the selected mode.
    always_comb begin
        pulse_raw = 1'b0;
        case (mode_d)
            MODE_SLOW: pulse_raw = phase_d[PW-1];
            MODE_MED:  pulse_raw = phase_d[PW-2];
            MODE_FAST: pulse_raw = phase_d[PW-3];
            default:   pulse_raw = 1'b0;
        endcase
    end

`ifdef PULSE_BURST_EN
    logic [2:0] idx_q, idx_d;
    logic       period_end;

    // Count fast-mode periods 0..5; muted from index 3 onward.
    always_comb begin
        period_end = &phase_q[DIV_BASE-1:0];
        idx_d      = idx_q;
        if (upd || (mode_d != MODE_FAST)) begin
            idx_d = '0;
        end else if (period_end) begin
            if (idx_q == 3'(BURST_PERIODS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    // Burst period index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign burst_mute = (idx_d >= 3'(BURST_ON));
`else
    assign burst_mute = 1'b0;
`endif

    assign pulse_d = pulse_raw & ~burst_mute;

    // Output and phase registers; reset aborts any pulse at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_OFF;
            chg_q   <= 1'b0;
            phase_q <= '0;
            pulse_q <= 1'b0;
            seg_q   <= SEG_OFF;
        end else begin
            mode_q  <= mode_d;
            chg_q   <= chg_d;
            phase_q <= phase_d;
            pulse_q <= pulse_d;
            seg_q   <= seg_d;
        end
    end

    assign mode      = mode_q;
    assign mode_chg  = chg_q;
    assign pulse_out = pulse_q;
    assign seg_n     = seg_q;

endmodule

// File: tb/tb_mode_pulse_decoder.sv
// Self-checking bench for mode_pulse_decoder: vector table, directed
// corner sequences and random codes against a behavioural model.
module tb_mode_pulse_decoder;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_a = 1'b0;
    logic       code_b = 1'b0;
    logic [1:0] mode;
    logic       mode_chg;
    logic       pulse_out;
    logic [6:0] seg_n;

    int checks = 0;
    int failures = 0;

    // Model state: code history (newest first), mode, strobe, cycles
    // since the last phase clear.
    logic [1:0] hist[$];
    logic [1:0] m_mode;
    logic       m_chg;
    int         m_cnt;
    logic [6:0] seg_tab[4];

    typedef struct {
        logic [1:0] code;
        logic [1:0] exp_mode;
        logic [6:0] exp_seg;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    mode_pulse_decoder #(.DIV_BASE(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code_a    (code_a),
        .code_b    (code_b),
        .mode      (mode),
        .mode_chg  (mode_chg),
        .pulse_out (pulse_out),
        .seg_n     (seg_n)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [6:0] got,
                       input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp,
                     $time);
        end
    endtask

    function automatic logic exp_pulse(input logic [1:0] md, input int c);
        int p;
        if (md == 2'd0) return 1'b0;
        p = 1 << (DB + 3 - int'(md));
`ifdef PULSE_BURST_EN
        if (md == 2'd3 && ((c / p) % 6) >= 3) return 1'b0;
`endif
        return (c % p) >= (p / 2);
    endfunction

    task automatic model_reset();
        hist = '{2'd0, 2'd0, 2'd0};
        m_mode = 2'd0;
        m_chg = 1'b0;
        m_cnt = 0;
    endtask

    // A code accepted at an edge is the one sampled two and three
    // edges earlier, provided both agree and differ from the mode.
    task automatic model_edge(input logic [1:0] c);
        logic u;
        u = (hist[1] == hist[2]) && (hist[1] != m_mode);
        if (u) begin
            m_mode = hist[1];
            m_cnt = 0;
        end else if (m_mode != 2'd0) begin
            m_cnt++;
        end
        m_chg = u;
        hist.push_front(c);
        void'(hist.pop_back());
    endtask

    task automatic check_all();
        chk("mode", 7'(mode), 7'(m_mode));
        chk("mode_chg", 7'(mode_chg), 7'(m_chg));
        chk("pulse_out", 7'(pulse_out), 7'(exp_pulse(m_mode, m_cnt)));
        chk("seg_n", seg_n, seg_tab[m_mode]);
    endtask

    task automatic tick(input logic [1:0] c);
        {code_b, code_a} = c;
        @(posedge clk);
        model_edge(c);
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_chg(input logic [1:0] c, input int max);
        int n;
        n = 0;
        do begin
            tick(c);
            n++;
        end while (!mode_chg && n < max);
        chk("chg_timeout", 7'(mode_chg), 7'd1);
    endtask

    initial begin
        int chg_cnt;
        int highs;
        int rises;
        logic last;
        int n;
        logic [1:0] c;
        int len;

        seg_tab[0] = 7'b1000000;
        seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000;
        vecs[0] = '{2'd0, 2'd0, 7'b1000000};
        vecs[1] = '{2'd1, 2'd1, 7'b1111001};
        vecs[2] = '{2'd2, 2'd2, 7'b0100100};
        vecs[3] = '{2'd3, 2'd3, 7'b0110000};
        vecs[4] = '{2'd0, 2'd0, 7'b1000000};
        vecs[5] = '{2'd2, 2'd2, 7'b0100100};

        // Reset held with code 3: outputs idle.
        rst_n = 1'b0;
        {code_b, code_a} = 2'd3;
        repeat (3) @(negedge clk);
        chk("rst_mode", 7'(mode), 7'd0);
        chk("rst_chg", 7'(mode_chg), 7'd0);
        chk("rst_pulse", 7'(pulse_out), 7'd0);
        chk("rst_seg", seg_n, 7'b1000000);

        // Release: mode 3 appears after the fourth edge with one strobe.
        rst_n = 1'b1;
        model_reset();
        chg_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(2'd3);
            if (mode_chg) chg_cnt++;
            if (i == 2) chk("rst_lat_pre", 7'(mode), 7'd0);
            if (i == 3) chk("rst_lat", 7'(mode), 7'd3);
        end
        chk("rst_chg_count", 7'(chg_cnt), 7'd1);

        // Table: each code step shows its digit after the latency.
        for (int i = 0; i < 6; i++) begin
            repeat (6) tick(vecs[i].code);
            chk("tab_mode", 7'(mode), 7'(vecs[i].exp_mode));
            chk("tab_seg", seg_n, vecs[i].exp_seg);
        end

        // Mode 1 from mode 0: period 64, 32 low then 32 high.
        repeat (6) tick(2'd0);
        wait_chg(2'd1, 10);
        chk("m1_first", 7'(pulse_out), 7'd0);
        highs = 0;
        rises = 0;
        last = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tick(2'd1);
            if (pulse_out) highs++;
            if (pulse_out && !last) rises++;
            last = pulse_out;
        end
        chk("m1_highs", 7'(highs), 7'(128));
        chk("m1_rises", 7'(rises), 7'd4);

        // Glitch rejection in mode 2.
        wait_chg(2'd2, 10);
        repeat (20) tick(2'd2);
        chg_cnt = 0;
        tick(2'd3);
        for (int i = 0; i < 10; i++) begin
            tick(2'd2);
            if (mode_chg) chg_cnt++;
        end
        chk("glitch_chg", 7'(chg_cnt), 7'd0);
        chk("glitch_mode", 7'(mode), 7'd2);

        // Mid-period change: mode 1 at phase 40, then code 2.
        wait_chg(2'd1, 10);
        repeat (40) tick(2'd1);
        chk("mid_high", 7'(pulse_out), 7'd1);
        wait_chg(2'd2, 10);
        chk("mid_pulse_chg", 7'(pulse_out), 7'd0);
        tick(2'd2);
        chk("mid_pulse_next", 7'(pulse_out), 7'd0);
        repeat (64) tick(2'd2);

        // Mode 3: burst or continuous period 16.
        wait_chg(2'd3, 10);
        rises = 0;
        last = 1'b0;
        for (int i = 0; i < 192; i++) begin
            tick(2'd3);
            if (pulse_out && !last) rises++;
            last = pulse_out;
        end
`ifdef PULSE_BURST_EN
        chk("m3_rises", 7'(rises), 7'd6);
`else
        chk("m3_rises", 7'(rises), 7'd12);
`endif

        // Async reset while the pulse is high.
        n = 0;
        do begin
            tick(2'd3);
            n++;
        end while (!pulse_out && n < 64);
        chk("pre_abort_high", 7'(pulse_out), 7'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_pulse", 7'(pulse_out), 7'd0);
        chk("abort_mode", 7'(mode), 7'd0);
        chk("abort_seg", seg_n, 7'b1000000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (8) tick(2'd3);

        // Random codes with random hold lengths, including glitches.
        for (int s = 0; s < 60; s++) begin
            c = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) len = 1;
            else len = int'($urandom_range(2, 40));
            repeat (len) tick(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
